// File: rtl/hart_pc_sequencer.sv
// Per-hart PC file with strict round-robin issue for the barrel core.
// Branch/jump resolutions rewrite a hart's PC; a same-cycle write to the issuing hart is bypassed.
module hart_pc_sequencer #(
  parameter int          NUM_HARTS = 16,
  localparam int         HART_W    = $clog2(NUM_HARTS),
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_hold,
  input  logic              i_res_valid,
  input  logic [HART_W-1:0] i_res_hart,
  input  logic [31:0]       i_res_pc,
  input  logic              i_is_branch_valid,
  input  logic              i_is_jump,
  input  logic [31:0]       i_target,
  output logic              o_issue_valid,
  output logic [HART_W-1:0] o_issue_hart,
  output logic [31:0]       o_issue_pc,
  output logic [31:0]       o_taken_cnt
);

  logic [31:0]       pc_file [NUM_HARTS];
  logic [HART_W-1:0] ptr;
  logic              taken;
  logic [31:0]       next_pc;
  logic [31:0]       issue_pc;

  // Bit 1 of the target is deliberately kept; misalignment is trapped further down the pipe.
  always_comb begin
    taken   = i_is_branch_valid | i_is_jump;
    next_pc = taken ? (i_target & ~32'd1) : (i_res_pc + 32'd4);
    if (i_res_valid && (i_res_hart == ptr)) begin
      issue_pc = next_pc;
    end else begin
      issue_pc = pc_file[ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        pc_file[h] <= RESET_PC;
      end
      ptr           <= '0;
      o_issue_valid <= 1'b0;
      o_issue_hart  <= '0;
      o_issue_pc    <= RESET_PC;
      o_taken_cnt   <= 32'd0;
    end else begin
      if (i_res_valid) begin
        pc_file[i_res_hart] <= next_pc;
        if (taken && (o_taken_cnt != 32'hFFFF_FFFF)) begin
          o_taken_cnt <= o_taken_cnt + 32'd1;
        end
      end
      // Hold only freezes rotation; the last issued hart/pc stay visible.
      if (i_hold) begin
        o_issue_valid <= 1'b0;
      end else begin
        o_issue_valid <= 1'b1;
        o_issue_hart  <= ptr;
        o_issue_pc    <= issue_pc;
        ptr           <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hart_pc_sequencer.sv
// Directed self-checking bench for hart_pc_sequencer: rotation, resolution, bypass, hold, wrap and reset.
module tb_hart_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        i_hold;
  logic        i_res_valid;
  logic [3:0]  i_res_hart;
  logic [31:0] i_res_pc;
  logic        i_is_branch_valid;
  logic        i_is_jump;
  logic [31:0] i_target;
  logic        o_issue_valid;
  logic [3:0]  o_issue_hart;
  logic [31:0] o_issue_pc;
  logic [31:0] o_taken_cnt;

  int checks;
  int failures;

  hart_pc_sequencer #(
    .NUM_HARTS(16),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_hold           (i_hold),
    .i_res_valid      (i_res_valid),
    .i_res_hart       (i_res_hart),
    .i_res_pc         (i_res_pc),
    .i_is_branch_valid(i_is_branch_valid),
    .i_is_jump        (i_is_jump),
    .i_target         (i_target),
    .o_issue_valid    (o_issue_valid),
    .o_issue_hart     (o_issue_hart),
    .o_issue_pc       (o_issue_pc),
    .o_taken_cnt      (o_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then let the edge happen and settle 1 time unit past it.
  task automatic applyStimulus(input logic hold, input logic rv, input logic [3:0] hart,
                               input logic [31:0] rpc, input logic br, input logic jmp,
                               input logic [31:0] tgt);
    i_hold            = hold;
    i_res_valid       = rv;
    i_res_hart        = hart;
    i_res_pc          = rpc;
    i_is_branch_valid = br;
    i_is_jump         = jmp;
    i_target          = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIssue(input string tag, input logic [3:0] hart, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, {31'd0, o_issue_valid}, 32'd1);
    checkOutput({tag, "_hart"}, {28'd0, o_issue_hart}, {28'd0, hart});
    checkOutput({tag, "_pc"}, o_issue_pc, pc);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    i_hold = 0; i_res_valid = 0; i_res_hart = 0; i_res_pc = 0;
    i_is_branch_valid = 0; i_is_jump = 0; i_target = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, o_issue_valid}, 32'd0);
    checkOutput("rst_hart", {28'd0, o_issue_hart}, 32'd0);
    checkOutput("rst_pc", o_issue_pc, 32'h0);
    checkOutput("rst_cnt", o_taken_cnt, 32'd0);

    // Full rotation plus wrap back to hart 0
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
      checkIssue("rot", i[3:0], 32'h0);
    end
    checkOutput("rot_cnt", o_taken_cnt, 32'd0);

    // Not-taken resolution of hart 3 while hart 1 issues
    applyStimulus(0, 1, 4'd3, 32'h100, 0, 0, 32'hDEAD_BEEF);
    checkIssue("nt_h1", 4'd1, 32'h0);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkIssue("nt_h2", 4'd2, 32'h0);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkIssue("nt_h3", 4'd3, 32'h104);
    checkOutput("nt_cnt", o_taken_cnt, 32'd0);

    // Taken branch for hart 5 with odd target, resolved while hart 4 issues
    applyStimulus(0, 1, 4'd5, 32'h500, 1, 0, 32'h2001);
    checkIssue("br_h4", 4'd4, 32'h0);
    checkOutput("br_cnt", o_taken_cnt, 32'd1);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkIssue("br_h5", 4'd5, 32'h2000);

    // Jump for hart 7 in the same cycle hart 7 issues
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkIssue("col_h6", 4'd6, 32'h0);
    applyStimulus(0, 1, 4'd7, 32'h700, 0, 1, 32'h400);
    checkIssue("col_h7", 4'd7, 32'h400);
    checkOutput("col_cnt", o_taken_cnt, 32'd2);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkIssue("pre_hold_h8", 4'd8, 32'h0);

    // Hold at ptr=9 for 4 cycles, with a hart-2 resolution (target bit 1 kept) arriving mid-hold
    applyStimulus(1, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkOutput("hold_valid0", {31'd0, o_issue_valid}, 32'd0);
    checkOutput("hold_hart0", {28'd0, o_issue_hart}, 32'd8);
    applyStimulus(1, 1, 4'd2, 32'h300, 1, 1, 32'h0000_3003);
    checkOutput("hold_valid1", {31'd0, o_issue_valid}, 32'd0);
    applyStimulus(1, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkOutput("hold_valid3", {31'd0, o_issue_valid}, 32'd0);
    checkOutput("hold_hart3", {28'd0, o_issue_hart}, 32'd8);
    checkOutput("hold_pc3", o_issue_pc, 32'h0);
    checkOutput("hold_cnt", o_taken_cnt, 32'd3);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkIssue("rel_h9", 4'd9, 32'h0);
    for (int h = 10; h < 18; h++) begin
      applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    end
    checkIssue("rel_h1", 4'd1, 32'h0);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkIssue("rel_h2", 4'd2, 32'h3002);
    applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
    checkIssue("rel_h3", 4'd3, 32'h104);

    // PC wrap via bypass: hart 4 resolves from 0xFFFF_FFFC in its own issue cycle
    applyStimulus(0, 1, 4'd4, 32'hFFFF_FFFC, 0, 0, 32'h0);
    checkIssue("wrap_h4", 4'd4, 32'h0);
    checkOutput("wrap_cnt", o_taken_cnt, 32'd3);

    // Reset with a resolution in flight discards everything
    reset = 1'b1;
    applyStimulus(0, 1, 4'd5, 32'h0, 0, 1, 32'h888);
    reset = 1'b0;
    checkOutput("rst2_valid", {31'd0, o_issue_valid}, 32'd0);
    checkOutput("rst2_hart", {28'd0, o_issue_hart}, 32'd0);
    checkOutput("rst2_pc", o_issue_pc, 32'h0);
    checkOutput("rst2_cnt", o_taken_cnt, 32'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 4'd0, 32'h0, 0, 0, 32'h0);
      checkIssue("rst2_rot", i[3:0], 32'h0);
    end
    checkOutput("rst2_cnt_end", o_taken_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
